// File: rtl/packet_pkg.sv
// Shared types for the port transmit engine: FSM states, queued descriptor,
// packet field layout and saturating/popcount helpers.
package packet_pkg;

    localparam int PACKET_WIDTH = 16;
    localparam int SRC_LSB      = 0;
    localparam int TGT_LSB      = 4;
    localparam int DATA_LSB     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        BACKOFF = 2'd2,
        DROP    = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [3:0] target;
        logic [7:0] data;
    } tx_desc_t;

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/tx_desc_fifo.sv
// Descriptor queue for port_tx_engine; DEPTH must be a power of two so the
// pointers wrap naturally.
module tx_desc_fifo
    import packet_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  tx_desc_t wr_desc,
    output tx_desc_t rd_desc,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    tx_desc_t        mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_desc   = mem_r[rd_ptr_r];

    // Storage array carries no reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_desc;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/port_tx_engine.sv
// Per-port transmit engine: queues descriptors and drives them into a switch
// input with retry/backoff/drop. Define PORT_TX_STATS_EN to build sent/drop counters.
module port_tx_engine
    import packet_pkg::*;
#(
    parameter int unsigned PORT_ID     = 0,
    parameter int          QDEPTH      = 4,
    parameter int          MAX_RETRY   = 8,
    parameter int          BACKOFF_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_target,
    input  logic [7:0]  req_data,
    output logic        tx_valid,
    output logic [3:0]  tx_source,
    output logic [3:0]  tx_target,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic        busy,
    output logic [15:0] sent_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
    localparam logic [3:0] BO_LAST     = (BACKOFF_CYC > 0) ? 4'(BACKOFF_CYC - 1) : 4'd0;
    localparam logic [3:0] SRC_ID      = 4'(PORT_ID);

    tx_state_t         state_r;
    tx_state_t         state_s;
    logic [7:0]        retry_r;
    logic [7:0]        retry_s;
    logic [3:0]        bo_r;
    logic [3:0]        bo_s;
    tx_desc_t          cur_desc_r;
    tx_desc_t          cur_desc_s;
    tx_desc_t          wr_desc_s;
    tx_desc_t          head_s;
    logic              pop_s;
    logic              push_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              accept_s;
    logic              drop_s;
    logic              send_next_s;
    logic              tx_valid_r;
    logic [3:0]        tx_target_r;
    logic [7:0]        tx_data_r;
    logic [PACKET_WIDTH-1:0] pkt_s;

    assign req_ready        = !rst && !fifo_full_s;
    assign push_s           = req_valid && req_ready;
    assign wr_desc_s.target = req_target;
    assign wr_desc_s.data   = req_data;
    assign busy             = !rst && (!fifo_empty_s || (state_r != IDLE));

    tx_desc_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_desc (wr_desc_s),
        .rd_desc (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Next-state, retry/backoff bookkeeping and descriptor capture.
    always_comb begin
        state_s    = state_r;
        retry_s    = retry_r;
        bo_s       = bo_r;
        cur_desc_s = cur_desc_r;
        pop_s      = 1'b0;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    retry_s    = 8'd0;
                    cur_desc_s = head_s;
                    // Target-less descriptors are swallowed without transmitting.
                    if (head_s.target != 4'd0) begin
                        state_s = SEND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (!tx_full) begin
                    accept_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    retry_s = retry_r + 8'd1;
                    bo_s    = 4'd0;
                    if (retry_s == RETRY_LIMIT) begin
                        state_s = DROP;
                    end else if (BACKOFF_CYC == 0) begin
                        state_s = SEND;
                    end else begin
                        state_s = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                if (bo_r == BO_LAST) begin
                    state_s = SEND;
                end else begin
                    bo_s    = bo_r + 4'd1;
                    state_s = BACKOFF;
                end
            end
            DROP: begin
                drop_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign send_next_s = (state_s == SEND);

    // State and registered switch-side outputs, zeroed outside SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            retry_r     <= 8'd0;
            bo_r        <= 4'd0;
            cur_desc_r  <= '0;
            tx_valid_r  <= 1'b0;
            tx_target_r <= 4'd0;
            tx_data_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            retry_r     <= retry_s;
            bo_r        <= bo_s;
            cur_desc_r  <= cur_desc_s;
            tx_valid_r  <= send_next_s;
            tx_target_r <= send_next_s ? cur_desc_s.target : 4'd0;
            tx_data_r   <= send_next_s ? cur_desc_s.data : 8'd0;
        end
    end

    assign pkt_s     = {tx_data_r, tx_target_r, SRC_ID};
    assign tx_valid  = tx_valid_r;
    assign tx_source = pkt_s[SRC_LSB +: 4];
    assign tx_target = pkt_s[TGT_LSB +: 4];
    assign tx_data   = pkt_s[DATA_LSB +: 8];

`ifdef PORT_TX_STATS_EN
    logic [15:0] sent_r;
    logic [15:0] drop_r;

    // Saturating statistics; drops are weighted by the number of targets lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_r <= 16'd0;
            drop_r <= 16'd0;
        end else begin
            if (accept_s) begin
                sent_r <= sat_add16(sent_r, 16'd1);
            end
            if (drop_s) begin
                drop_r <= sat_add16(drop_r, {13'd0, popcount4(cur_desc_r.target)});
            end
        end
    end

    assign sent_cnt = sent_r;
    assign drop_cnt = drop_r;
`else
    logic unused_stats_s;
    assign unused_stats_s = accept_s ^ drop_s;
    assign sent_cnt       = 16'd0;
    assign drop_cnt       = 16'd0;
`endif

endmodule

// File: tb/tb_port_tx_engine.sv
// Directed self-checking bench for port_tx_engine (PORT_ID=2, QDEPTH=4,
// MAX_RETRY=8, BACKOFF_CYC=2); counter expectations follow PORT_TX_STATS_EN.
module tb_port_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_target;
    logic [7:0]  req_data;
    logic        tx_valid;
    logic [3:0]  tx_source;
    logic [3:0]  tx_target;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        busy;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    port_tx_engine #(
        .PORT_ID     (2),
        .QDEPTH      (4),
        .MAX_RETRY   (8),
        .BACKOFF_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_data   (req_data),
        .tx_valid   (tx_valid),
        .tx_source  (tx_source),
        .tx_target  (tx_target),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .busy       (busy),
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] ev(input int n);
`ifdef PORT_TX_STATS_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] q_tgt [6];
    logic [7:0] q_dat [6];

    initial begin
        int idx;
        int blocked_at;
        int got;
        int n;
        int budget;
        logic rdy;
        logic [3:0] last_tgt;
        logic [7:0] last_dat;

        rst = 1'b1; req_valid = 1'b0; req_target = 4'd0; req_data = 8'd0; tx_full = 1'b0;
        tick();
        tick();
        chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        chk("rst_tx_target", {12'd0, tx_target}, 16'd0);
        chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_req_ready", {15'd0, req_ready}, 16'd0);
        chk("rst_tx_source", {12'd0, tx_source}, 16'd2);
        chk("rst_sent", sent_cnt, 16'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {15'd0, req_ready}, 16'd1);

        // Basic send: tx_valid two cycles after enqueue.
        req_valid = 1'b1; req_target = 4'b0010; req_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        chk("lat_cyc1_valid", {15'd0, tx_valid}, 16'd0);
        chk("lat_cyc1_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("lat_cyc2_valid", {15'd0, tx_valid}, 16'd1);
        chk("lat_source", {12'd0, tx_source}, 16'd2);
        chk("lat_target", {12'd0, tx_target}, 16'h2);
        chk("lat_data", {8'd0, tx_data}, 16'hA5);
        tick();
        chk("lat_after_valid", {15'd0, tx_valid}, 16'd0);
        chk("lat_sent", sent_cnt, ev(1));
        chk("lat_idle_busy", {15'd0, busy}, 16'd0);

        // Three refusals with backoff then accept.
        tx_full = 1'b1;
        req_valid = 1'b1; req_target = 4'b0001; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("retry_pattern", {15'd0, tx_valid}, (i % 3 == 0) ? 16'd1 : 16'd0);
            chk("retry_data", {8'd0, tx_data}, (i % 3 == 0) ? 16'h3C : 16'd0);
            if (i == 9) tx_full = 1'b0;
            tick();
        end
        chk("retry_done_valid", {15'd0, tx_valid}, 16'd0);
        chk("retry_sent", sent_cnt, ev(2));
        chk("retry_drop", drop_cnt, 16'd0);

        // Permanent back-pressure: 8 SEND cycles then drop.
        tx_full = 1'b1;
        req_valid = 1'b1; req_target = 4'b1011; req_data = 8'h77;
        tick();
        req_valid = 1'b0;
        n = 0;
        budget = 0;
        while (busy && budget < 80) begin
            if (tx_valid) n++;
            budget++;
            tick();
        end
        chk("drop_send_cycles", 16'(n), 16'd8);
        chk("drop_busy", {15'd0, busy}, 16'd0);
        chk("drop_cnt", drop_cnt, ev(3));
        chk("drop_sent", sent_cnt, ev(2));

        // Fill the queue while blocked, then drain in order.
        for (int i = 0; i < 6; i++) begin
            q_tgt[i] = 4'(4'd1 << (i % 4));
            q_dat[i] = 8'(8'h10 + i);
        end
        idx = 0;
        blocked_at = -1;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1; req_target = q_tgt[idx]; req_data = q_dat[idx];
            rdy = req_ready;
            if (!rdy && blocked_at < 0) blocked_at = idx;
            tick();
            if (rdy) idx++;
        end
        chk("fill_blocked_at", 16'(blocked_at), 16'd5);
        chk("fill_ready_low", {15'd0, req_ready}, 16'd0);
        tx_full = 1'b0;
        got = 0;
        budget = 0;
        while (got < 6 && budget < 80) begin
            if (tx_valid && !tx_full) begin
                chk("order_target", {12'd0, tx_target}, {12'd0, q_tgt[got]});
                chk("order_data", {8'd0, tx_data}, {8'd0, q_dat[got]});
                got++;
            end
            rdy = req_valid && req_ready;
            tick();
            if (rdy) begin
                idx++;
                req_valid = 1'b0;
            end
            budget++;
        end
        req_valid = 1'b0;
        chk("order_count", 16'(got), 16'd6);
        tick();
        chk("order_sent", sent_cnt, ev(8));
        chk("order_busy", {15'd0, busy}, 16'd0);

        // Reset during BACKOFF with two descriptors still queued.
        tx_full = 1'b1;
        req_valid = 1'b1; req_target = 4'b0001; req_data = 8'hE1;
        tick();
        req_target = 4'b0010; req_data = 8'hE2;
        tick();
        req_target = 4'b0100; req_data = 8'hE3;
        tick();
        req_valid = 1'b0;
        chk("bo_valid", {15'd0, tx_valid}, 16'd0);
        chk("bo_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_sent", sent_cnt, 16'd0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        rst = 1'b0;
        tx_full = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx_valid) n++;
            tick();
        end
        chk("no_stale_pkt", 16'(n), 16'd0);
        chk("post_rst_busy", {15'd0, busy}, 16'd0);

        // Zero-target descriptor is consumed silently.
        req_valid = 1'b1; req_target = 4'b0000; req_data = 8'h11;
        tick();
        req_target = 4'b0100; req_data = 8'h22;
        tick();
        req_valid = 1'b0;
        n = 0;
        last_tgt = 4'd0;
        last_dat = 8'd0;
        for (int c = 0; c < 10; c++) begin
            if (tx_valid && !tx_full) begin
                n++;
                last_tgt = tx_target;
                last_dat = tx_data;
            end
            tick();
        end
        chk("zero_tgt_count", 16'(n), 16'd1);
        chk("zero_tgt_target", {12'd0, last_tgt}, 16'h4);
        chk("zero_tgt_data", {8'd0, last_dat}, 16'h22);
        chk("zero_tgt_sent", sent_cnt, ev(1));
        chk("zero_tgt_drop", drop_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
